// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the decode-side fetch queue.
//   if_stage_out_t : one fetched beat {inst, pc, pc4} as produced by IF
//   fq_status_t    : occupancy summary {count, full, empty}
//   NOP_INST       : addi x0,x0,0 presented to ID when nothing is valid
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int FQ_PTR_W = $clog2(FQ_DEPTH);
    localparam int FQ_CNT_W = FQ_PTR_W + 1;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_stage_out_t;

    typedef struct packed {
        logic [FQ_CNT_W-1:0] count;
        logic                full;
        logic                empty;
    } fq_status_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between IF, the fetch queue and ID.
//   master : the IF/ID side (drives fetched beats, flush and ID ready)
//   slave  : the fetch queue (drives the head entry, stall and occupancy)
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) ();

    localparam int CNT_W = $clog2(DEPTH) + 1;

    if_stage_out_t    if_out_i;
    logic             if_valid_i;
    logic             flush_i;
    logic             stall_o;
    logic [31:0]      id_inst_o;
    logic [31:0]      id_pc_o;
    logic [31:0]      id_pc4_o;
    logic             id_valid_o;
    logic             id_ready_i;
    logic [CNT_W-1:0] count_o;

    modport master (
        output if_out_i, if_valid_i, flush_i, id_ready_i,
        input  stall_o, id_inst_o, id_pc_o, id_pc4_o, id_valid_o, count_o
    );

    modport slave (
        input  if_out_i, if_valid_i, flush_i, id_ready_i,
        output stall_o, id_inst_o, id_pc_o, id_pc4_o, id_valid_o, count_o
    );

endinterface

// File: rtl/fetch_queue_fq_ptr.sv
// Wrap-around FIFO pointer.
//   clk, rst : clock, synchronous active-high reset (pointer to 0)
//   clr      : return pointer to 0 (flush)
//   inc      : advance by one; wraps naturally because depth is a power of 2
//   ptr_o    : current pointer value
module fq_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between IF and ID: small first-word-fall-through FIFO of fetched
// beats. Stalls IF while full and drops all (wrong-path) entries on flush.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : fetch_queue_if.slave -- IF beat in, flush, ID handshake out,
//              stall_o to IF, count_o occupancy
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // The status struct is sized from the package depth, so the two must agree.
    generate
        if (DEPTH != FQ_DEPTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_queue: DEPTH must be a power of 2, >= 2, and equal FQ_DEPTH");
        end
    endgenerate

    if_stage_out_t    mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    fq_status_t       st;
    logic             push;
    logic             pop;
    logic             head_valid;
    if_stage_out_t    head;

    always_comb begin
        st       = '0;
        st.count = count_q;
        st.full  = (count_q == CNT_W'(DEPTH));
        st.empty = (count_q == '0);
    end

    // Flush hides the head in the same cycle so ID never consumes a wrong-path entry.
    assign head_valid = ~st.empty & ~bus.flush_i;
    assign push       = bus.if_valid_i & ~st.full & ~bus.flush_i;
    assign pop        = head_valid & bus.id_ready_i;

    always_comb begin
        count_d = count_q;
        if (bus.flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage holds data only; validity lives entirely in count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= bus.if_out_i;
        end
    end

    fq_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush_i),
        .inc   (push),
        .ptr_o (wr_ptr)
    );

    fq_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush_i),
        .inc   (pop),
        .ptr_o (rd_ptr)
    );

    assign head = mem_q[rd_ptr];

    assign bus.id_valid_o = head_valid;
    assign bus.id_inst_o  = head_valid ? head.inst : NOP_INST;
    assign bus.id_pc_o    = head_valid ? head.pc   : 32'h0;
    assign bus.id_pc4_o   = head_valid ? head.pc4  : 32'h0;
    assign bus.stall_o    = st.full;
    assign bus.count_o    = st.count;

endmodule
